// File: rtl/fifo_wr_ctrl_pkg.sv
// Shared widths and types for the FIFO write-control slice.
package fifo_wr_ctrl_pkg;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned ADDR_W = 4;
  localparam int unsigned DEPTH  = 1 << ADDR_W;

  typedef logic              bit_t;
  typedef logic [ADDR_W-1:0] RAM_size;
  typedef logic [ADDR_W:0]   count_t;
  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/fifo_occupancy.sv
// Occupancy counter with full/empty decode; shared by write- and read-side status logic.
module fifo_occupancy #(
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_inc,
  input  logic            i_dec,
  output logic [ADDR_W:0] o_count,
  output logic            o_full,
  output logic            o_empty
);

  localparam int unsigned     CNT_W   = ADDR_W + 1;
  localparam logic [ADDR_W:0] DEPTH_C = CNT_W'(1 << ADDR_W);

  logic [ADDR_W:0] r_count;

  // Simultaneous inc and dec cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({i_inc, i_dec})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_full  = (r_count == DEPTH_C);
  assign o_empty = (r_count == '0);

endmodule

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side control: accepts push/pop, drives the RAM write port, forwards legal pops
// and keeps sticky overflow/underflow flags.
module fifo_wr_ctrl
  import fifo_wr_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] w_add,
  output logic              w_en,
  output logic [DATA_W-1:0] w_data,
  output logic              pop_o,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic              underflow
);

  RAM_size r_wptr;
  bit_t    r_overflow;
  bit_t    r_underflow;
  bit_t    w_push_acc;
  bit_t    w_pop_acc;
  bit_t    w_full;
  bit_t    w_empty;
  count_t  w_count;

  // A full FIFO still takes a push when a legal pop frees a slot on the same edge.
  always_comb begin
    w_pop_acc  = pop & ~w_empty;
    w_push_acc = push & (~w_full | w_pop_acc);
    w_en       = w_push_acc;
    w_add      = r_wptr;
    w_data     = w_push_acc ? data_in : '0;
    pop_o      = w_pop_acc;
  end

  // Write pointer walks downward to match the read pointer; a new error beats clr_err.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wptr      <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wptr <= r_wptr - ADDR_W'(w_push_acc);
      if (push & ~w_push_acc) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end
      if (pop & ~w_pop_acc) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  fifo_occupancy #(
    .ADDR_W (ADDR_W)
  ) u_occupancy (
    .clk     (clk),
    .rst_n   (reset),
    .i_inc   (w_push_acc),
    .i_dec   (w_pop_acc),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign count     = w_count;
  assign full      = w_full;
  assign empty     = w_empty;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Self-checking bench for fifo_wr_ctrl against an arithmetic occupancy/pointer model.
module tb_fifo_wr_ctrl;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [7:0] data_in;
  logic       clr_err;
  logic [3:0] w_add;
  logic       w_en;
  logic [7:0] w_data;
  logic       pop_o;
  logic [4:0] count;
  logic       full;
  logic       empty;
  logic       overflow;
  logic       underflow;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int m_count = 0;
  int m_wptr  = 0;
  bit m_ovf   = 0;
  bit m_unf   = 0;
  bit e_push, e_pop;
  bit s_push, s_pop, s_clr;

  fifo_wr_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .data_in   (data_in),
    .clr_err   (clr_err),
    .w_add     (w_add),
    .w_en      (w_en),
    .w_data    (w_data),
    .pop_o     (pop_o),
    .count     (count),
    .full      (full),
    .empty     (empty),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Apply inputs just after a rising edge, then move to the falling edge for sampling.
  task automatic drive(input bit p, input bit q, input logic [7:0] d, input bit c);
    push = p; pop = q; data_in = d; clr_err = c;
    s_push = p; s_pop = q; s_clr = c;
    e_pop  = q && (m_count != 0);
    e_push = p && ((m_count != 16) || e_pop);
    @(negedge clk);
  endtask

  task automatic advance();
    @(posedge clk);
    if (s_push && !e_push) m_ovf = 1'b1;
    else if (s_clr)        m_ovf = 1'b0;
    if (s_pop && !e_pop)   m_unf = 1'b1;
    else if (s_clr)        m_unf = 1'b0;
    m_count = m_count + int'(e_push) - int'(e_pop);
    m_wptr  = (m_wptr + 16 - int'(e_push)) % 16;
    #1;
  endtask

  task automatic model_reset();
    m_count = 0; m_wptr = 0; m_ovf = 0; m_unf = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; push = 0; pop = 0; data_in = '0; clr_err = 0;
    s_push = 0; s_pop = 0; s_clr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    model_reset();
    repeat (5) begin drive(0, 0, 8'h00, 0); advance(); end
    drive(0, 0, 8'h00, 0);
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL reset_empty got %b exp 1", empty); end
    checks++; if (full !== 1'b0)   begin errors++; $display("FAIL reset_full got %b exp 0", full); end
    checks++; if (count !== 5'd0)  begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (w_en !== 1'b0)   begin errors++; $display("FAIL reset_w_en got %b exp 0", w_en); end
    checks++; if (pop_o !== 1'b0)  begin errors++; $display("FAIL reset_pop_o got %b exp 0", pop_o); end
    checks++; if (w_add !== 4'd0)  begin errors++; $display("FAIL reset_w_add got %0d exp 0", w_add); end
    checks++; if ({overflow, underflow} !== 2'b00)
      begin errors++; $display("FAIL reset_flags got %b%b exp 00", overflow, underflow); end
    advance();
  endtask

  task automatic test_fill();
    int exp_add;
    for (int i = 0; i < 16; i++) begin
      drive(1, 0, 8'(i), 0);
      exp_add = (16 - i) % 16;
      checks++; if (w_en !== 1'b1) begin errors++; $display("FAIL fill_w_en[%0d] got %b exp 1", i, w_en); end
      checks++; if (w_add !== 4'(exp_add))
        begin errors++; $display("FAIL fill_w_add[%0d] got %0d exp %0d", i, w_add, exp_add); end
      checks++; if (w_data !== 8'(i))
        begin errors++; $display("FAIL fill_w_data[%0d] got %0h exp %0h", i, w_data, i); end
      advance();
    end
    drive(1, 0, 8'h55, 0);
    checks++; if (count !== 5'd16) begin errors++; $display("FAIL full_count got %0d exp 16", count); end
    checks++; if (full !== 1'b1)   begin errors++; $display("FAIL full_flag got %b exp 1", full); end
    checks++; if (empty !== 1'b0)  begin errors++; $display("FAIL full_empty got %b exp 0", empty); end
    checks++; if (w_en !== 1'b0)   begin errors++; $display("FAIL push_on_full_w_en got %b exp 0", w_en); end
    advance();
    drive(0, 0, 8'h00, 0);
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL overflow_set got %b exp 1", overflow); end
    checks++; if (count !== 5'd16)   begin errors++; $display("FAIL overflow_count got %0d exp 16", count); end
    advance();
  endtask

  task automatic test_full_push_pop();
    drive(0, 0, 8'h00, 1);
    advance();
    drive(1, 1, 8'hAA, 0);
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_overflow got %b exp 0", overflow); end
    checks++; if (w_en !== 1'b1)     begin errors++; $display("FAIL fullpp_w_en got %b exp 1", w_en); end
    checks++; if (pop_o !== 1'b1)    begin errors++; $display("FAIL fullpp_pop_o got %b exp 1", pop_o); end
    checks++; if (w_data !== 8'hAA)  begin errors++; $display("FAIL fullpp_w_data got %0h exp aa", w_data); end
    checks++; if (w_add !== 4'd0)    begin errors++; $display("FAIL fullpp_w_add got %0d exp 0", w_add); end
    advance();
    drive(0, 0, 8'h00, 0);
    checks++; if (count !== 5'd16)   begin errors++; $display("FAIL fullpp_count got %0d exp 16", count); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL fullpp_overflow got %b exp 0", overflow); end
    checks++; if (w_add !== 4'd15)   begin errors++; $display("FAIL fullpp_wptr got %0d exp 15", w_add); end
    advance();
  endtask

  task automatic test_underflow();
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 8'h00, 0);
      checks++; if (pop_o !== 1'b1) begin errors++; $display("FAIL drain_pop_o[%0d] got %b exp 1", i, pop_o); end
      advance();
    end
    drive(0, 1, 8'h00, 0);
    checks++; if (empty !== 1'b1)  begin errors++; $display("FAIL drained_empty got %b exp 1", empty); end
    checks++; if (pop_o !== 1'b0)  begin errors++; $display("FAIL pop_on_empty got %b exp 0", pop_o); end
    advance();
    drive(0, 1, 8'h00, 1);
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL underflow_set got %b exp 1", underflow); end
    advance();
    drive(0, 0, 8'h00, 1);
    checks++; if (underflow !== 1'b1)
      begin errors++; $display("FAIL error_beats_clr got %b exp 1", underflow); end
    advance();
    drive(1, 1, 8'h3C, 0);
    checks++; if (underflow !== 1'b0) begin errors++; $display("FAIL clr_underflow got %b exp 0", underflow); end
    checks++; if (w_en !== 1'b1)  begin errors++; $display("FAIL emptypp_w_en got %b exp 1", w_en); end
    checks++; if (pop_o !== 1'b0) begin errors++; $display("FAIL emptypp_pop_o got %b exp 0", pop_o); end
    advance();
    drive(0, 0, 8'h00, 0);
    checks++; if (count !== 5'd1)     begin errors++; $display("FAIL emptypp_count got %0d exp 1", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL emptypp_underflow got %b exp 1", underflow); end
    advance();
  endtask

  task automatic test_random();
    bit p, q, c;
    logic [7:0] d;
    for (int i = 0; i < 80; i++) begin
      p = ($urandom_range(0, 9) < 6);
      q = ($urandom_range(0, 9) < 5);
      c = ($urandom_range(0, 9) == 0);
      d = 8'($urandom);
      drive(p, q, d, c);
      checks++;
      if (w_en !== e_push || pop_o !== e_pop || w_add !== 4'(m_wptr) || count !== 5'(m_count) ||
          full !== (m_count == 16) || empty !== (m_count == 0) ||
          overflow !== m_ovf || underflow !== m_unf || (e_push && w_data !== d)) begin
        errors++;
        $display("FAIL random[%0d] got en=%b po=%b add=%0d cnt=%0d f=%b e=%b ov=%b un=%b exp en=%b po=%b add=%0d cnt=%0d ov=%b un=%b",
                 i, w_en, pop_o, w_add, count, full, empty, overflow, underflow,
                 e_push, e_pop, m_wptr, m_count, m_ovf, m_unf);
      end
      advance();
    end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 20 && m_count > 0; i++) begin drive(0, 1, 8'h00, 0); advance(); end
    drive(0, 1, 8'h00, 0); advance();
    for (int i = 0; i < 7; i++) begin drive(1, 0, 8'($urandom), 0); advance(); end
    drive(0, 0, 8'h00, 0);
    checks++; if (count !== 5'd7)     begin errors++; $display("FAIL pre_reset_count got %0d exp 7", count); end
    checks++; if (underflow !== 1'b1) begin errors++; $display("FAIL pre_reset_underflow got %b exp 1", underflow); end
    #1 reset = 1'b0;
    #1;
    checks++; if (count !== 5'd0) begin errors++; $display("FAIL async_count got %0d exp 0", count); end
    checks++; if (empty !== 1'b1 || full !== 1'b0)
      begin errors++; $display("FAIL async_flags got e=%b f=%b exp e=1 f=0", empty, full); end
    checks++; if (w_add !== 4'd0) begin errors++; $display("FAIL async_w_add got %0d exp 0", w_add); end
    checks++; if ({overflow, underflow} !== 2'b00)
      begin errors++; $display("FAIL async_err got %b%b exp 00", overflow, underflow); end
    checks++; if (w_en !== 1'b0 || pop_o !== 1'b0)
      begin errors++; $display("FAIL async_outs got en=%b po=%b exp 0 0", w_en, pop_o); end
    model_reset();
    s_push = 0; s_pop = 0; s_clr = 0;
    @(posedge clk); #1 reset = 1'b1;
    drive(0, 0, 8'h00, 0);
    checks++; if (count !== 5'd0 || empty !== 1'b1)
      begin errors++; $display("FAIL post_reset got cnt=%0d e=%b exp 0 1", count, empty); end
    advance();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_push_pop();
    test_underflow();
    test_random();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
